// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU share arbiter: opcodes, FSM states,
// result width and the operand sign-extension helper.
package alu_pkg;

  localparam int RES_W = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_LNOT = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic [RES_W-1:0] sext4(input logic [3:0] v);
    return {{(RES_W-4){v[3]}}, v};
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters, the response consumer and
// the arbiter. The master side drives requests and rsp_ready.
interface alu_share_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic [3*N_REQ-1:0] req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [7:0]         rsp_result;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/alu_4bit.sv
// 4-bit signed ALU with 8-bit sign-extended result; output is forced to zero
// while enable is low so nothing undefined leaks downstream.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [2:0]       opcode,
  input  logic             enable,
  output logic [RES_W-1:0] result
);

  // Opcode decode on sign-extended operands
  always_comb begin
    result = '0;
    if (enable) begin
      case (opcode)
        OP_ADD:  result = sext4(a) + sext4(b);
        OP_SUB:  result = sext4(a) - sext4(b);
        OP_INC:  result = sext4(a) + 8'd1;
        OP_DEC:  result = sext4(a) - 8'd1;
        OP_LNOT: result = (a == 4'd0) ? 8'h01 : 8'h00;
        OP_NOT:  result = ~sext4(a);
        OP_OR:   result = sext4(a) | sext4(b);
        OP_AND:  result = sext4(a) & sext4(b);
        default: result = '0;
      endcase
    end else begin
      result = '0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid request at or after
// last_grant+1 (mod N_REQ) wins; zero grant when nothing is requesting.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic            hit_s;
  logic [ID_W-1:0] cand_s;

  // Rotating priority scan; the first hit locks the result
  always_comb begin
    grant  = '0;
    idx    = '0;
    hit_s  = 1'b0;
    cand_s = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s = ID_W'((int'(last_grant) + i) % N_REQ);
      if (!hit_s && req[cand_s]) begin
        hit_s         = 1'b1;
        idx           = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_4bit among N_REQ requesters: IDLE grants round-robin, EXEC
// computes, RESP holds the tagged result. ALU_ARB_STATS_EN adds grant counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ALU_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [8*N_REQ-1:0] grant_cnt,
`endif
  alu_share_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t       state_r;
  arb_state_t       state_s;
  logic [ID_W-1:0]  last_grant_r;
  logic [3:0]       op_a_r;
  logic [3:0]       op_b_r;
  logic [2:0]       op_code_r;
  logic             rsp_valid_r;
  logic [ID_W-1:0]  rsp_id_r;
  logic [RES_W-1:0] rsp_result_r;

  logic [N_REQ-1:0] pick_grant_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic [N_REQ-1:0] req_ready_s;
  logic             accept_s;
  logic             rsp_fire_s;
  logic             alu_en_s;
  logic [RES_W-1:0] alu_result_s;
  logic [3:0]       sel_a_s;
  logic [3:0]       sel_b_s;
  logic [2:0]       sel_op_s;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .idx        (pick_idx_s)
  );

  alu_4bit u_alu (
    .a      (op_a_r),
    .b      (op_b_r),
    .opcode (op_code_r),
    .enable (alu_en_s),
    .result (alu_result_s)
  );

  // Operand mux for the picked requester (grant is one-hot or zero)
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s  = sel_a_s  | (bus.req_a[4*i +: 4]  & {4{pick_grant_s[i]}});
      sel_b_s  = sel_b_s  | (bus.req_b[4*i +: 4]  & {4{pick_grant_s[i]}});
      sel_op_s = sel_op_s | (bus.req_op[3*i +: 3] & {3{pick_grant_s[i]}});
    end
  end

  // Next-state, accept strobe and ALU enable
  always_comb begin
    state_s     = state_r;
    req_ready_s = '0;
    accept_s    = 1'b0;
    rsp_fire_s  = 1'b0;
    alu_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (|pick_grant_s) begin
          req_ready_s = pick_grant_s;
          accept_s    = 1'b1;
          state_s     = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        alu_en_s = 1'b1;
        state_s  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and latched operation; last_grant doubles as the owner id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= ID_W'(N_REQ - 1);
      op_a_r       <= '0;
      op_b_r       <= '0;
      op_code_r    <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        last_grant_r <= pick_idx_s;
        op_a_r       <= sel_a_s;
        op_b_r       <= sel_b_s;
        op_code_r    <= sel_op_s;
      end
    end
  end

  // Response registers: loaded in EXEC, held until the consumer takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= '0;
    end else if (state_r == EXEC) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= last_grant_r;
      rsp_result_r <= alu_result_s;
    end else if (rsp_fire_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.busy       = (state_r != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [8*N_REQ-1:0] grant_cnt_r;

  // Saturating per-requester accept counters; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_r <= '0;
    end else if (stats_clr) begin
      grant_cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept_s && pick_grant_s[i] && (grant_cnt_r[8*i +: 8] != 8'hFF)) begin
          grant_cnt_r[8*i +: 8] <= grant_cnt_r[8*i +: 8] + 8'd1;
        end
      end
    end
  end

  assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random
// traffic checked cycle by cycle against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N_REQ(N)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic         stats_clr = 1'b0;
  logic [8*N-1:0] grant_cnt;
`endif

  alu_share_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ALU_ARB_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit         m_pending;
  int         m_age;
  int         m_last;
  int         m_id;
  logic [7:0] m_res;
  int         m_cnt [N];
  int         cyc;
  int         log_id [$];
  int         log_cyc [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [7:0] exp_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int sa, sb, r;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    case (op)
      3'd0: r = sa + sb;
      3'd1: r = sa - sb;
      3'd2: r = sa + 1;
      3'd3: r = sa - 1;
      3'd4: r = (sa == 0) ? 1 : 0;
      3'd5: r = -sa - 1;
      3'd6: r = sa | sb;
      default: r = sa & sb;
    endcase
    return r[7:0];
  endfunction

  // Evaluated mid-cycle: check outputs, then advance the model over the coming edge
  task automatic model_check();
    logic [N-1:0] exp_ready;
    int g;
    exp_ready = '0;
    g = -1;
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[8*i +: 8], m_cnt[i][7:0]);
`endif
    if (!m_pending) begin
      for (int k = 1; k <= N; k++)
        if (g < 0 && bus.req_valid[(m_last + k) % N]) g = (m_last + k) % N;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready_idle", bus.req_ready, exp_ready);
      chk("busy_idle", bus.busy, 0);
      chk("rsp_valid_idle", bus.rsp_valid, 0);
      if (g >= 0) begin
        m_pending = 1'b1;
        m_age     = 0;
        m_last    = g;
        m_id      = g;
        m_res     = exp_alu(bus.req_a[4*g +: 4], bus.req_b[4*g +: 4], bus.req_op[3*g +: 3]);
      end
    end else if (m_age == 0) begin
      chk("req_ready_exec", bus.req_ready, 0);
      chk("busy_exec", bus.busy, 1);
      chk("rsp_valid_exec", bus.rsp_valid, 0);
      m_age = 1;
    end else begin
      chk("req_ready_resp", bus.req_ready, 0);
      chk("busy_resp", bus.busy, 1);
      chk("rsp_valid_resp", bus.rsp_valid, 1);
      chk("rsp_id", bus.rsp_id, m_id);
      chk("rsp_result", bus.rsp_result, m_res);
      log_id.push_back(int'(bus.rsp_id));
      log_cyc.push_back(cyc);
      if (bus.rsp_ready) m_pending = 1'b0;
    end
`ifdef ALU_ARB_STATS_EN
    if (stats_clr) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (g >= 0 && m_cnt[g] < 255) begin
      m_cnt[g] = m_cnt[g] + 1;
    end
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.req_a[4*i +: 4]  = a;
    bus.req_b[4*i +: 4]  = b;
    bus.req_op[3*i +: 3] = op;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_busy", bus.busy, 0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_grant_cnt", grant_cnt, 0);
`endif
    m_pending = 1'b0;
    m_last    = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b0;
    reset_dut();

    // single request from requester 2: 7 + 1
    bus.rsp_ready = 1'b1;
    set_req(2, 4'd7, 4'd1, 3'b000);
    bus.req_valid = 4'b0100;
    #1;
    chk("t1_ready_pulse", bus.req_ready, 4'b0100);
    cycle();
    bus.req_valid = '0;
    cycle();
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_id", bus.rsp_id, 2);
    chk("t1_rsp_result", bus.rsp_result, 8'h08);
    cycle();

    // -8 + -1 from requester 0, then logical-not of zero from requester 1
    set_req(0, 4'b1000, 4'b1111, 3'b000);
    bus.req_valid = 4'b0001;
    cycle();
    bus.req_valid = '0;
    cycle();
    chk("t2_rsp_result", bus.rsp_result, 8'hF7);
    cycle();
    set_req(1, 4'd0, 4'd5, 3'b100);
    bus.req_valid = 4'b0010;
    cycle();
    bus.req_valid = '0;
    cycle();
    chk("t3_rsp_result", bus.rsp_result, 8'h01);
    cycle();

    // all requesters continuously valid from reset
    reset_dut();
    log_id.delete();
    log_cyc.delete();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    for (int c = 0; c < 18; c++) begin
      rand_ops();
      cycle();
    end
    chk("rr_count", (log_id.size() >= 6), 1);
    for (int k = 0; k < 6 && k < log_id.size(); k++) begin
      chk("rr_order", log_id[k], k % N);
      if (k > 0) chk("rr_period", log_cyc[k] - log_cyc[k-1], 3);
    end

    // backpressure: rsp_ready low for five RESP cycles
    bus.req_valid = '0;
    cycle();
    bus.rsp_ready = 1'b0;
    set_req(3, 4'd3, 4'd2, 3'b110);
    bus.req_valid = 4'b1000;
    cycle();
    bus.req_valid = '1;
    cycle();
    for (int c = 0; c < 5; c++) begin
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_result", bus.rsp_result, 8'h03);
      cycle();
    end
    bus.rsp_ready = 1'b1;
    cycle();
    bus.req_valid = '0;
    chk("stall_release_idle", bus.busy, 0);

    // reset while in EXEC
    set_req(2, 4'd1, 4'd1, 3'b000);
    bus.req_valid = 4'b0100;
    cycle();
    chk("exec_busy", bus.busy, 1);
    reset_dut();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("rst_regrant", bus.req_ready, 4'b0001);
    for (int c = 0; c < 6; c++) cycle();
    bus.req_valid = '0;
    cycle();
    cycle();
    cycle();

`ifdef ALU_ARB_STATS_EN
    // counter saturation and clear
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 900; c++) begin
      rand_ops();
      cycle();
    end
    bus.req_valid = '0;
    cycle();
    cycle();
    cycle();
    chk("cnt_saturate", grant_cnt[15:8], 8'hFF);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    chk("cnt_clear", grant_cnt[15:8], 8'h00);
`endif

    // random traffic
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = N'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
`ifdef ALU_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 63) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Round-robin arbiter and sequencer that shares one `alu_4bit` instance among `N_REQ` requesters.
- Each requester submits an operation (A, B, opcode) over a valid/ready handshake.
- The arbiter grants one requester, drives the ALU with Enable asserted for one cycle, and registers the 8-bit result.
- It returns the result, tagged with the requester index, on a single response channel with backpressure.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2–8.
- `ID_W`, `$clog2(N_REQ)`: width of the requester index. Derived; not overridden.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept; one-hot or zero.
- `req_a` in 4*N_REQ: signed A operand, requester i at bits [4i+3:4i].
- `req_b` in 4*N_REQ: signed B operand, same packing as `req_a`.
- `req_op` in 3*N_REQ: opcode, requester i at bits [3i+2:3i].
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out ID_W: index of the requester that owns the response.
- `rsp_result` out 8: ALU result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Round-robin search starts at `(last_grant+1) mod N_REQ` over `req_valid`.
  - If a requester is found: assert `req_ready[g]` combinationally, latch `{a, b, op, g}`, set `last_grant = g`, go to EXEC.
  - If none is found: stay in IDLE with `req_ready = 0`.
- **EXEC**
  - ALU Enable = 1 with the latched operands.
  - Register the ALU Result into `rsp_result` and g into `rsp_id`.
  - Set `rsp_valid`, go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_id` and `rsp_result` stable until `rsp_valid && rsp_ready`.
  - On that handshake go to IDLE.
- ALU Enable = 0 in IDLE and RESP. The ALU output is never sampled while Enable is low, so X never propagates.
- Arithmetic and width rules are those of the ALU:
  - Signed 4-bit operands.
  - Ops 000 add, 001 sub, 010 A+1, 011 A−1, 101 ~A and 110 |, 111 & are sign-extended to 8 bits.
  - Op 100 is logical-not: 8'h01 if A==0, else 8'h00.
- `req_ready` is never asserted for a requester whose `req_valid` is low.
- At most one grant is in flight; no new request is accepted until the RESP handshake.
- `last_grant` resets to N_REQ−1, so requester 0 has first priority after reset.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept per requester.
- Reset mid-operation: the FSM returns to IDLE and the in-flight operation is discarded; no response is issued.

## Timing
- All outputs reset to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_result`, `busy`.
- `req_ready` is combinational from the state and `req_valid`; acceptance happens on the IDLE cycle edge.
- Latency: request accept edge → `rsp_valid` high two cycles later.
- With `rsp_ready` tied high, the minimum period is 3 cycles per operation: IDLE, EXEC, RESP.
- Simultaneous `req_valid` from all requesters with `rsp_ready = 1` gives grants in order 0,1,2,3,0… with no starvation.
- `rsp_ready` low in RESP stalls the FSM indefinitely; outputs stay stable.

## Configuration
- Macro: `ALU_ARB_STATS_EN`.
- Defined:
  - Adds output `grant_cnt` of width 8*N_REQ.
  - Each 8-bit count increments on that requester's accept and saturates at 8'hFF.
  - Counts clear on reset or on input `stats_clr` (1 bit, synchronous; clear wins over increment).
- Undefined: the `grant_cnt` and `stats_clr` ports and all counter logic are absent; all other behaviour is identical.

## Structure
- Package `alu_pkg` holds:
  - Opcode localparams: OP_ADD … OP_AND.
  - State enum `arb_state_t` with IDLE, EXEC, RESP.
  - The 8-bit result width constant.
- One sub-module `rr_pick`: combinational round-robin selector. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and the index.
- `alu_4bit` is instantiated once inside the arbiter.

## Test plan
- Reset, then a single request from requester 2 with A=7, B=1, op=000:
  - `req_ready[2]` pulses.
  - `rsp_valid` appears two cycles later with `rsp_id` = 2 and `rsp_result` = 8'h08.
- Requester 0 with A=−8, B=−1, op=000 → `rsp_result` = 8'hF7. Requester 1 with A=0, op=100 → 8'h01.
- All four requesters valid continuously with `rsp_ready` = 1 → `rsp_id` sequence is 0,1,2,3,0,1 at one response every 3 cycles.
- `rsp_ready` held low for 5 cycles in RESP:
  - Response held stable and `req_ready` = 0 throughout.
  - Handshake on the 6th cycle → IDLE.
- Assert `rst_n` low during EXEC → all outputs 0 immediately; no response after release; next grant goes to requester 0.
- `ALU_ARB_STATS_EN` defined, 300 grants to requester 1:
  - `grant_cnt[1]` = 8'hFF.
  - `stats_clr` pulse → 0.
